reg_pc_bank: RTL

- Architectural state store for the 16-bit core: eight general-purpose registers r0-r7 plus the program counter.
- All nine values are presented continuously to the downstream 9-channel register/PC bus multiplexer (channel 0-7 = r0-r7, channel 8 = pc).
- Accepts one register write-back per cycle.
- Sequences the PC: hold, increment, load, and halt/resume. Call/return is optional.

---
 rtl/reg_pc_bank_if.sv | 37 +++
 rtl/reg_pc_bank.sv | 125 ++++++++++++
 2 files changed

// File: rtl/reg_pc_bank_if.sv
// Write-back, PC-control and architectural-state bus of reg_pc_bank.
// master drives the controls and observes the nine register/PC channels.
interface reg_pc_bank_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 3
);
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 pc_inc;
    logic                 pc_load;
    logic [WORD_SIZE-1:0] pc_target;
    logic                 call;
    logic                 ret;
    logic                 halt;
    logic                 resume;
    logic [WORD_SIZE-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [WORD_SIZE-1:0] pc;
    logic                 halted;
    logic                 stk_empty;
    logic                 stk_full;
    logic                 stk_err;

    modport master (
        output wr_en, wr_addr, wr_data, pc_inc, pc_load, pc_target,
               call, ret, halt, resume,
        input  r0, r1, r2, r3, r4, r5, r6, r7, pc, halted,
               stk_empty, stk_full, stk_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, pc_inc, pc_load, pc_target,
               call, ret, halt, resume,
        output r0, r1, r2, r3, r4, r5, r6, r7, pc, halted,
               stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/reg_pc_bank.sv
// Eight GPRs plus PC sequencer (hold/inc/load/halt/resume) for the 16-bit core.
// Define RET_STACK_EN to build the call/return address stack.
module reg_pc_bank #(
    parameter int                   WORD_SIZE    = 16,
    parameter int                   ADDR_SIZE    = 3,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter int                   STACK_DEPTH  = 4
) (
    input logic          clk,
    input logic          rst_n,
    reg_pc_bank_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t               state;
    logic                 halted_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] regs [2**ADDR_SIZE];
    logic                 pc_ops;

    // PC operations only take effect in RUN and not in the cycle that halts.
    assign pc_ops = (state == RUN) && !bus.halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_SIZE; i++) regs[i] <= '0;
        end else if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.r0 = regs[0];
    assign bus.r1 = regs[1];
    assign bus.r2 = regs[2];
    assign bus.r3 = regs[3];
    assign bus.r4 = regs[4];
    assign bus.r5 = regs[5];
    assign bus.r6 = regs[6];
    assign bus.r7 = regs[7];

`ifdef RET_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WORD_SIZE-1:0] stk [STACK_DEPTH];
    logic [SP_W-1:0]      sp;
    logic [SP_W-1:0]      sp_dec;
    logic                 stk_full_w;
    logic                 stk_empty_w;
    logic                 err_q;
    logic                 push;
    logic                 pop;
    logic                 fault;

    assign stk_full_w  = (sp == SP_W'(STACK_DEPTH));
    assign stk_empty_w = (sp == '0);
    assign sp_dec      = sp - 1'b1;
    assign pop         = pc_ops && bus.ret && !stk_empty_w;
    assign push        = pc_ops && !bus.ret && bus.call && !stk_full_w;
    assign fault       = pc_ops && ((bus.ret && stk_empty_w) ||
                                    (!bus.ret && bus.call && stk_full_w));

    always_ff @(posedge clk) begin
        if (push) stk[sp[IDX_W-1:0]] <= pc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push)      sp <= sp + 1'b1;
            else if (pop)  sp <= sp_dec;
            if (fault)     err_q <= 1'b1;
        end
    end

    assign bus.stk_empty = stk_empty_w;
    assign bus.stk_full  = stk_full_w;
    assign bus.stk_err   = err_q;
`else
    assign bus.stk_empty = 1'b1;
    assign bus.stk_full  = 1'b0;
    assign bus.stk_err   = 1'b0;
`endif

    // ret > call > pc_load > pc_inc > hold; without the stack, ret just holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_VECTOR;
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.ret) begin
`ifdef RET_STACK_EN
                        if (!stk_empty_w) pc_q <= stk[sp_dec[IDX_W-1:0]];
`endif
                    end else if (bus.call || bus.pc_load) begin
                        pc_q <= bus.pc_target;
                    end else if (bus.pc_inc) begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                HALT: begin
                    if (bus.resume && !bus.halt) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;
endmodule
